xfer_sequencer: RTL and testbench

Cycle-accurate sequencer for the memory-to-memory transfer datapath. It replaces the free-running counter and controller pair with a start/done-driven FSM. The FSM:
- loads memory A through a valid/ready handshake;
- rewinds and streams A out;
- issues one memory-B write per adjacent pair of A words, timed so that the current read word and its registered predecessor are both present at the write.

It sits beside the datapath and drives the A/B write enables and address-counter controls.

---
 rtl/xfer_pkg.sv | 36 +++
 rtl/xfer_sequencer_pulse_delay.sv | 43 ++++
 rtl/xfer_sequencer.sv | 159 +++++++++++++++
 tb/tb_xfer_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/xfer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xfer_pkg
// Description : Shared types and constants for the transfer sequencer:
//               FSM state encoding, default geometry and a constant-width
//               helper used to size the beat counter.
// Revision    : 1.0 - initial release
// ============================================================================
package xfer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } xfer_state_t;

    localparam int unsigned c_depth_a = 8;
    localparam int unsigned c_depth_b = 4;
    localparam int unsigned c_rd_lat  = 1;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xfer_sequencer_pulse_delay.sv
`default_nettype none
// ============================================================================
// Module      : pulse_delay
// Description : N-deep single-bit shift register; q reproduces d delayed by
//               N clocks. Cleared by the synchronous reset.
// Ports       : clk, rst (sync, active-high), d (pulse in), q (pulse out)
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_delay #(
    parameter int unsigned N = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] r_sr;

    generate
        if (N == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= d;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[N-2:0], d};
                end
            end
        end
    endgenerate

    assign q = r_sr[N-1];

endmodule
`default_nettype wire

// File: rtl/xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : xfer_sequencer
// Description : Start/done driven controller for the memory-to-memory
//               transfer datapath. Fills memory A through a valid/ready
//               handshake, streams A back out, and writes one B word per
//               adjacent pair of A words once both words are on the read
//               outputs.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               start          - begin a transfer (honoured in IDLE only)
//               in_valid       - external word present on the A write data
//               in_ready       - accepting words (FILL)
//               wea/inc_a/clr_a- memory A write enable, address inc/clear
//               web/inc_b/clr_b- memory B write enable, address inc/clear
//               busy           - FILL, READ or DRAIN in progress
//               done           - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module xfer_sequencer
    import xfer_pkg::*;
#(
    parameter int unsigned DEPTH_A = c_depth_a,
    parameter int unsigned DEPTH_B = c_depth_b,
    parameter int unsigned RD_LAT  = c_rd_lat
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    output logic wea,
    output logic inc_a,
    output logic clr_a,
    output logic web,
    output logic inc_b,
    output logic clr_b,
    output logic busy,
    output logic done
);

    localparam int unsigned c_cnt_w = clog2(DEPTH_A) + 1;
    localparam logic [c_cnt_w-1:0] c_last_a   = c_cnt_w'(DEPTH_A - 1);
    localparam logic [c_cnt_w-1:0] c_last_lat = c_cnt_w'(RD_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    generate
        if ((DEPTH_A < 2) || ((DEPTH_A & (DEPTH_A - 1)) != 0)) begin : g_bad_depth_a
            $error("xfer_sequencer: DEPTH_A must be a power of two >= 2");
        end
        if (DEPTH_B != (DEPTH_A / 2)) begin : g_bad_depth_b
            $error("xfer_sequencer: DEPTH_B must equal DEPTH_A/2");
        end
        if ((RD_LAT < 1) || (RD_LAT > 3)) begin : g_bad_rd_lat
            $error("xfer_sequencer: RD_LAT must be 1..3");
        end
    endgenerate

    xfer_state_t        r_state;
    xfer_state_t        w_state_nxt;
    // Shared counter: accepted beats in FILL, issue index in READ,
    // elapsed cycles in DRAIN. Cleared on every state change.
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_push;
    logic               w_dq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        in_ready    = 1'b0;
        wea         = 1'b0;
        inc_a       = 1'b0;
        clr_a       = 1'b0;
        clr_b       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    clr_a       = 1'b1;
                    clr_b       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                wea      = in_valid;
                inc_a    = in_valid;
                if (in_valid) begin
                    // Counter A wraps to 0 on the last beat, so READ
                    // starts at address 0 without an explicit clear.
                    if (r_cnt == c_last_a) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = READ;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
            end
            READ: begin
                busy  = 1'b1;
                inc_a = 1'b1;
                // Odd address: its word and the previous one complete a
                // pair once the read latency has elapsed.
                w_push = r_cnt[0];
                if (r_cnt == c_last_a) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (r_cnt == c_last_lat) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    pulse_delay #(
        .N (RD_LAT)
    ) u_web_delay (
        .clk (clk),
        .rst (rst),
        .d   (w_push),
        .q   (w_dq)
    );

    assign web   = w_dq;
    assign inc_b = w_dq;

endmodule
`default_nettype wire

// File: tb/tb_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_xfer_sequencer
// Description : Directed bench for xfer_sequencer. Two instances share the
//               stimulus: u_dut1 with RD_LAT=1 and u_dut2 with RD_LAT=2.
//               A small datapath model follows u_dut1's controls so the B
//               contents can be checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xfer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] din;

    logic in_ready, wea, inc_a, clr_a, web, inc_b, clr_b, busy, done;
    logic in_ready2, wea2, inc_a2, clr_a2, web2, inc_b2, clr_b2, busy2, done2;

    xfer_sequencer #(.DEPTH_A(8), .DEPTH_B(4), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .wea(wea), .inc_a(inc_a), .clr_a(clr_a),
        .web(web), .inc_b(inc_b), .clr_b(clr_b), .busy(busy), .done(done)
    );

    xfer_sequencer #(.DEPTH_A(8), .DEPTH_B(4), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready2), .wea(wea2), .inc_a(inc_a2), .clr_a(clr_a2),
        .web(web2), .inc_b(inc_b2), .clr_b(clr_b2), .busy(busy2), .done(done2)
    );

    logic [8:0] w_v1;
    logic [8:0] w_v2;
    assign w_v1 = {in_ready, wea, inc_a, clr_a, clr_b, web, inc_b, busy, done};
    assign w_v2 = {in_ready2, wea2, inc_a2, clr_a2, clr_b2, web2, inc_b2, busy2, done2};

    // Datapath model driven by u_dut1: A counter/memory, RD_LAT=1 read,
    // registered previous word, B counter/memory holding {DOut2, DOut1}.
    logic [2:0]  m_ca;
    logic [1:0]  m_cb;
    logic [7:0]  m_a [8];
    logic [7:0]  m_d1, m_d2;
    logic [15:0] m_b [4];

    always @(posedge clk) begin
        if (clr_a)      m_ca <= 3'd0;
        else if (inc_a) m_ca <= m_ca + 3'd1;
        if (wea) m_a[m_ca] <= din;
        m_d1 <= m_a[m_ca];
        m_d2 <= m_d1;
        if (clr_b)      m_cb <= 2'd0;
        else if (inc_b) m_cb <= m_cb + 2'd1;
        if (web) m_b[m_cb] <= {m_d2, m_d1};
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected output vector for a transfer started at cycle 0 whose last
    // FILL beat lands at cycle 'last'; vld is in_valid for that cycle.
    function automatic logic [8:0] exp_vec(input int c, input int lat, input int last, input bit vld);
        logic ir, we, ia, cl, wb, bz, dn;
        int   d;
        ir = (c >= 1) && (c <= last);
        we = ir && vld;
        ia = we || ((c > last) && (c <= last + 8));
        cl = (c == 0);
        d  = c - (last + 2 + lat);
        wb = (d >= 0) && (d <= 6) && ((d % 2) == 0);
        bz = (c >= 1) && (c <= last + 8 + lat);
        dn = (c == last + 9 + lat);
        return {ir, we, ia, cl, cl, wb, wb, bz, dn};
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; din = 8'h00;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic run_nominal(input string tag);
        int n_web;
        n_web = 0;
        for (int c = 0; c <= 20; c++) begin
            start = (c == 0); in_valid = 1'b1; din = 8'(c);
            @(negedge clk);
            n_web += int'(web);
            check($sformatf("%s_lat1_c%0d", tag, c), 32'(w_v1), 32'(exp_vec(c, 1, 8, 1'b1)));
            check($sformatf("%s_lat2_c%0d", tag, c), 32'(w_v2), 32'(exp_vec(c, 2, 8, 1'b1)));
            next_cycle();
        end
        check({tag, "_web_count"}, 32'(n_web), 32'd4);
        check({tag, "_b_addr_wrap"}, 32'(m_cb), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_b%0d", tag, k), 32'(m_b[k]),
                  32'({8'(2 * k + 1), 8'(2 * k + 2)}));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int n_wea, n_done, n_clr, n_web;

        // Reset values
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; din = 8'h00;
        next_cycle(); next_cycle(); next_cycle();
        @(negedge clk);
        check("reset_lat1", 32'(w_v1), 32'd0);
        check("reset_lat2", 32'(w_v2), 32'd0);
        next_cycle();
        rst = 1'b0; in_valid = 1'b0;

        // Reset held for 3 cycles during FILL
        for (int c = 0; c <= 8; c++) begin
            start = (c == 0);
            in_valid = (c >= 1);
            rst = (c >= 4) && (c <= 6);
            din = 8'hA0;
            @(negedge clk);
            if (c == 2) check("rstfill_active", 32'(w_v1), 32'(exp_vec(2, 1, 8, 1'b1)));
            if (c >= 5 && c <= 7) begin
                check($sformatf("rstfill_lat1_c%0d", c), 32'(w_v1), 32'd0);
                check($sformatf("rstfill_lat2_c%0d", c), 32'(w_v2), 32'd0);
            end
            next_cycle();
        end
        rst = 1'b0; in_valid = 1'b0; start = 1'b0;
        next_cycle();

        // Nominal transfer, both latencies
        run_nominal("nom");

        // Gapped fill: valid on odd cycles, last beat at cycle 15
        n_wea = 0;
        for (int c = 0; c <= 27; c++) begin
            start = (c == 0);
            in_valid = (c >= 1) && ((c % 2) == 1);
            din = in_valid ? 8'(8'h20 + (c - 1) / 2) : 8'hEE;
            @(negedge clk);
            n_wea += int'(wea);
            check($sformatf("gap_lat1_c%0d", c), 32'(w_v1), 32'(exp_vec(c, 1, 15, in_valid)));
            check($sformatf("gap_lat2_c%0d", c), 32'(w_v2), 32'(exp_vec(c, 2, 15, in_valid)));
            next_cycle();
        end
        in_valid = 1'b0;
        check("gap_wea_count", 32'(n_wea), 32'd8);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("gap_b%0d", k), 32'(m_b[k]),
                  32'({8'(8'h20 + 2 * k), 8'(8'h21 + 2 * k)}));
        end

        // Ignored inputs: in_valid in IDLE, start in READ and DONE
        in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("idle_valid_c%0d", c), 32'(w_v1), 32'd0);
            next_cycle();
        end
        n_done = 0; n_clr = 0;
        for (int c = 0; c <= 20; c++) begin
            start = (c == 0) || (c == 12) || (c == 13) || (c == 18) || (c == 19);
            in_valid = 1'b1; din = 8'(c);
            @(negedge clk);
            if (c <= 18) begin
                n_done += int'(done);
                if (c >= 1) n_clr += int'(clr_a);
                check($sformatf("ign_lat1_c%0d", c), 32'(w_v1), 32'(exp_vec(c, 1, 8, 1'b1)));
            end
            if (c <= 19)
                check($sformatf("ign_lat2_c%0d", c), 32'(w_v2), 32'(exp_vec(c, 2, 8, 1'b1)));
            if (c == 19) check("restart_after_done", 32'(w_v1), 32'(9'b000110000));
            if (c == 20) begin
                check("restart_fill", 32'(w_v1), 32'(9'b111000010));
                check("start_in_done_ignored", 32'(w_v2), 32'd0);
            end
            next_cycle();
        end
        check("ign_done_count", 32'(n_done), 32'd1);
        check("ign_clr_count", 32'(n_clr), 32'd0);
        do_reset();

        // Reset mid-READ, then a fresh transfer
        n_web = 0;
        for (int c = 0; c <= 14; c++) begin
            start = (c == 0); in_valid = 1'b1; din = 8'(c);
            rst = (c == 12);
            @(negedge clk);
            n_web += int'(web);
            if (c == 13) begin
                check("rstread_lat1", 32'(w_v1), 32'd0);
                check("rstread_lat2", 32'(w_v2), 32'd0);
            end
            next_cycle();
        end
        rst = 1'b0;
        check("rstread_web_count", 32'(n_web), 32'd1);
        run_nominal("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
